// File: rtl/lmdpl_phase_ctrl.sv
// Sequencer for one masked LMDPL gate: operand accept, mask fetch, table load, precharge, evaluate, respond.
// Optional bring-up self-check of the unmasked result is compiled in with LMDPL_SELFCHECK_EN (adds port err).
module lmdpl_phase_ctrl #(
  parameter int unsigned PRECHARGE_CYCLES = 1,
  parameter int unsigned EVAL_CYCLES      = 2,
  parameter int unsigned MASK_REUSE       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic       op_in0,
  input  logic       op_in1,
  input  logic       mask_valid,
  output logic       mask_ready,
  input  logic [2:0] mask_data,
  output logic       gate_precharge,
  output logic       gate_in0,
  output logic       gate_in1,
  output logic       gate_m_in0,
  output logic       gate_m_in1,
  output logic       gate_m_out,
  input  logic       gate_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_data,
  output logic       busy
`ifdef LMDPL_SELFCHECK_EN
  ,
  output logic       err
`endif
);

  localparam int unsigned PH_W = 4;
  localparam int unsigned RU_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_MFETCH = 3'd1;
  localparam logic [2:0] ST_TABLE  = 3'd2;
  localparam logic [2:0] ST_PRE    = 3'd3;
  localparam logic [2:0] ST_EVAL   = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  // Phase counters count down to zero; load value is cycles-1.
  localparam logic [PH_W-1:0] PRE_LOAD  = PH_W'(PRECHARGE_CYCLES - 1);
  localparam logic [PH_W-1:0] EVAL_LOAD = PH_W'(EVAL_CYCLES - 1);
  localparam logic [RU_W-1:0] RU_LOAD   = RU_W'(MASK_REUSE);

  logic [2:0]      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [RU_W-1:0] reuse_q, reuse_d;
  logic            in0_q, in0_d;
  logic            in1_q, in1_d;
  logic            m_in0_q, m_in0_d;
  logic            m_in1_q, m_in1_d;
  logic            m_out_q, m_out_d;
  logic            res_data_q, res_data_d;
  logic            op_ready_q, op_ready_d;
  logic            mask_ready_q, mask_ready_d;
  logic            precharge_q, precharge_d;
  logic            res_valid_q, res_valid_d;
  logic            busy_q, busy_d;
`ifdef LMDPL_SELFCHECK_EN
  logic            err_q, err_d;
`endif

  // Next-state, datapath latches and output decode from the next state.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    reuse_d    = reuse_q;
    in0_d      = in0_q;
    in1_d      = in1_q;
    m_in0_d    = m_in0_q;
    m_in1_d    = m_in1_q;
    m_out_d    = m_out_q;
    res_data_d = res_data_q;
`ifdef LMDPL_SELFCHECK_EN
    err_d      = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          in0_d   = op_in0;
          in1_d   = op_in1;
          state_d = (reuse_q == '0) ? ST_MFETCH : ST_TABLE;
        end
      end
      ST_MFETCH: begin
        if (mask_valid) begin
          m_in0_d = mask_data[0];
          m_in1_d = mask_data[1];
          m_out_d = mask_data[2];
          reuse_d = RU_LOAD;
          state_d = ST_TABLE;
        end
      end
      ST_TABLE: begin
        if (reuse_q != '0) begin
          reuse_d = reuse_q - RU_W'(1);
        end
        phase_d = PRE_LOAD;
        state_d = ST_PRE;
      end
      ST_PRE: begin
        if (phase_q == '0) begin
          phase_d = EVAL_LOAD;
          state_d = ST_EVAL;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_EVAL: begin
        if (phase_q == '0) begin
          res_data_d = gate_out;
`ifdef LMDPL_SELFCHECK_EN
          // Bring-up only: recombines unmasked operands.
          err_d = err_q | (gate_out != ~(in0_q & in1_q));
`endif
          state_d = ST_RESP;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    op_ready_d   = (state_d == ST_IDLE);
    mask_ready_d = (state_d == ST_MFETCH);
    precharge_d  = (state_d != ST_EVAL);
    res_valid_d  = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      reuse_q      <= '0;
      in0_q        <= 1'b0;
      in1_q        <= 1'b0;
      m_in0_q      <= 1'b0;
      m_in1_q      <= 1'b0;
      m_out_q      <= 1'b0;
      res_data_q   <= 1'b0;
      op_ready_q   <= 1'b1;
      mask_ready_q <= 1'b0;
      precharge_q  <= 1'b1;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LMDPL_SELFCHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      reuse_q      <= reuse_d;
      in0_q        <= in0_d;
      in1_q        <= in1_d;
      m_in0_q      <= m_in0_d;
      m_in1_q      <= m_in1_d;
      m_out_q      <= m_out_d;
      res_data_q   <= res_data_d;
      op_ready_q   <= op_ready_d;
      mask_ready_q <= mask_ready_d;
      precharge_q  <= precharge_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
`ifdef LMDPL_SELFCHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign op_ready       = op_ready_q;
  assign mask_ready     = mask_ready_q;
  assign gate_precharge = precharge_q;
  assign gate_in0       = in0_q;
  assign gate_in1       = in1_q;
  assign gate_m_in0     = m_in0_q;
  assign gate_m_in1     = m_in1_q;
  assign gate_m_out     = m_out_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign busy           = busy_q;
`ifdef LMDPL_SELFCHECK_EN
  assign err            = err_q;
`endif

endmodule
